// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB3 bridge.
package axil_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase cycle counter; flags the cycle in which the wait budget runs out.
module apb_timeout_cnt #(
    parameter int C_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(C_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The count reaches C_TIMEOUT at the end of this ACCESS cycle.
    assign expired = enable && (cnt_q == CW'(C_TIMEOUT - 1));

endmodule

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge: one transfer at a time, read/write
// round-robin arbitration, and a PREADY timeout with a sticky flag.
module axil_apb_bridge
    import axil_apb_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_APB_ADDR_WIDTH   = 16,
    parameter int C_TIMEOUT          = 1023
) (
    input  logic                          ACLK,
    input  logic                          nRST,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AWADDR,
    input  logic                          S_AWVALID,
    output logic                          S_AWREADY,
    input  logic [APB_DATA_W-1:0]         S_WDATA,
    input  logic [3:0]                    S_WSTRB,
    input  logic                          S_WVALID,
    output logic                          S_WREADY,
    output logic [1:0]                    S_BRESP,
    output logic                          S_BVALID,
    input  logic                          S_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_ARADDR,
    input  logic                          S_ARVALID,
    output logic                          S_ARREADY,
    output logic [APB_DATA_W-1:0]         S_RDATA,
    output logic [1:0]                    S_RRESP,
    output logic                          S_RVALID,
    input  logic                          S_RREADY,
    output logic                          M_PSEL,
    output logic                          M_PENABLE,
    output logic                          M_PWRITE,
    output logic [C_APB_ADDR_WIDTH-1:0]   M_PADDR,
    output logic [APB_DATA_W-1:0]         M_PWDATA,
    input  logic [APB_DATA_W-1:0]         M_PRDATA,
    input  logic                          M_PREADY,
    input  logic                          M_PSLVERR,
    output logic                          TIMEOUT
);

    state_t                        state_q, state_d;
    logic                          prefer_read_q;
    logic                          write_q;
    logic                          timeout_q;
    logic [C_APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [APB_DATA_W-1:0]         pwdata_q;
    logic [APB_DATA_W-1:0]         rdata_q;
    logic [1:0]                    resp_q;
    logic                          psel_q, penable_q;
    logic                          bvalid_q, rvalid_q;

    logic wr_cand, rd_cand, full_strb;
    logic grant_w, grant_r;
    logic apb_done, apb_abort;
    logic cnt_clr, cnt_en, cnt_expired;
    logic addr_unused;

    assign wr_cand   = S_AWVALID & S_WVALID;
    assign rd_cand   = S_ARVALID;
    assign full_strb = (S_WSTRB == 4'hF);
    assign cnt_en    = (state_q == ACCESS);
    assign cnt_clr   = (state_q == IDLE) && (state_d == SETUP);

    // Only the forwarded slice of each address reaches PADDR.
    assign addr_unused = ^{S_AWADDR, S_ARADDR};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        grant_w   = 1'b0;
        grant_r   = 1'b0;
        apb_done  = 1'b0;
        apb_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_cand && (!rd_cand || !prefer_read_q)) begin
                    grant_w = 1'b1;
                    state_d = full_strb ? SETUP : RESP;
                end else if (rd_cand) begin
                    grant_r = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (M_PREADY) begin
                    apb_done = 1'b1;
                    state_d  = RESP;
                end else if (cnt_expired) begin
                    apb_abort = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (write_q ? S_BREADY : S_RREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            prefer_read_q <= 1'b1;
            write_q       <= 1'b0;
            timeout_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_OKAY;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
        end else begin
            psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q <= (state_d == ACCESS);
            // Only a write can jump from IDLE straight to RESP (partial strobe).
            bvalid_q  <= (state_d == RESP) && (grant_w || ((state_q != IDLE) && write_q));
            rvalid_q  <= (state_d == RESP) && (state_q != IDLE) && !write_q;

            // Favour the side that was not granted last.
            if (grant_w || grant_r) prefer_read_q <= grant_w;

            if (grant_w) begin
                write_q  <= 1'b1;
                paddr_q  <= {S_AWADDR[C_APB_ADDR_WIDTH-1:2], 2'b00};
                pwdata_q <= S_WDATA;
                resp_q   <= full_strb ? RESP_OKAY : RESP_SLVERR;
            end else if (grant_r) begin
                write_q <= 1'b0;
                paddr_q <= {S_ARADDR[C_APB_ADDR_WIDTH-1:2], 2'b00};
            end

            if (apb_done) begin
                resp_q <= M_PSLVERR ? RESP_SLVERR : RESP_OKAY;
                if (!write_q) rdata_q <= M_PRDATA;
            end

            if (apb_abort) begin
                resp_q    <= RESP_SLVERR;
                timeout_q <= 1'b1;
                if (!write_q) rdata_q <= '0;
            end
        end
    end

    apb_timeout_cnt #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout_cnt (
        .clk     (ACLK),
        .rst_n   (nRST),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    // Ready pulses are decoded in the grant cycle so a grant costs no extra cycle.
    assign S_AWREADY = grant_w;
    assign S_WREADY  = grant_w;
    assign S_ARREADY = grant_r;

    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = resp_q;
    assign S_RVALID  = rvalid_q;
    assign S_RRESP   = resp_q;
    assign S_RDATA   = rdata_q;
    assign M_PSEL    = psel_q;
    assign M_PENABLE = penable_q;
    assign M_PWRITE  = write_q;
    assign M_PADDR   = paddr_q;
    assign M_PWDATA  = pwdata_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Directed scoreboard bench for axil_apb_bridge with a configurable APB slave.
module tb_axil_apb_bridge;
    import axil_apb_pkg::*;

    localparam int AW  = 32;
    localparam int PW  = 16;
    localparam int TMO = 8;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic [PW-1:0] paddr;
        logic [31:0]   pwdata;
        bit            pwrite;
    } apb_t;

    logic          ACLK = 1'b0;
    logic          nRST;
    logic [AW-1:0] S_AWADDR;
    logic          S_AWVALID, S_AWREADY;
    logic [31:0]   S_WDATA;
    logic [3:0]    S_WSTRB;
    logic          S_WVALID, S_WREADY;
    logic [1:0]    S_BRESP;
    logic          S_BVALID, S_BREADY;
    logic [AW-1:0] S_ARADDR;
    logic          S_ARVALID, S_ARREADY;
    logic [31:0]   S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RVALID, S_RREADY;
    logic          M_PSEL, M_PENABLE, M_PWRITE;
    logic [PW-1:0] M_PADDR;
    logic [31:0]   M_PWDATA, M_PRDATA;
    logic          M_PREADY, M_PSLVERR;
    logic          TIMEOUT;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    apb_t apb_exp[$];
    bit   grants[$];

    // APB slave model knobs
    int          slv_wait = 0;
    bit          slv_hang = 1'b0;
    bit          slv_err  = 1'b0;
    bit          slv_mix  = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt = 0;

    int cyc = 0;
    int hs_cyc = 0;
    int b_cyc = 0;
    int pen_cnt = 0;
    int psel_rise = 0;
    int rise0 = 0;
    int n_wait = 0;
    int rd_n = 0;
    int wr_n = 0;
    bit psel_prev = 1'b0;
    bit rd_hs, wr_hs;

    always #5 ACLK = ~ACLK;

    axil_apb_bridge #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_APB_ADDR_WIDTH   (PW),
        .C_TIMEOUT          (TMO)
    ) dut (
        .ACLK      (ACLK),
        .nRST      (nRST),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWRITE  (M_PWRITE),
        .M_PADDR   (M_PADDR),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .M_PSLVERR (M_PSLVERR),
        .TIMEOUT   (TIMEOUT)
    );

    assign M_PREADY  = M_PSEL && M_PENABLE && !slv_hang && (acc_cnt == slv_wait);
    assign M_PSLVERR = slv_err;
    assign M_PRDATA  = slv_mix ? (slv_rdata ^ {16'h0, M_PADDR}) : slv_rdata;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (M_PSEL && M_PENABLE && !M_PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic got_resp(input bit is_w, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        check("resp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_kind", 32'(is_w), 32'(e.is_write));
            check("resp_code", 32'(resp), 32'(e.resp));
            if (!is_w) check("rdata", data, e.data);
        end
    endtask

    // Response and APB monitors, sampled on the falling edge
    always @(negedge ACLK) begin
        if (S_BVALID && S_BREADY) begin
            b_cyc = cyc;
            got_resp(1'b1, 32'h0, S_BRESP);
        end
        if (S_RVALID && S_RREADY) got_resp(1'b0, S_RDATA, S_RRESP);
    end

    always @(negedge ACLK) begin
        apb_t a;
        if (M_PENABLE) pen_cnt++;
        if (M_PSEL && !psel_prev) psel_rise++;
        psel_prev = M_PSEL;
        if (M_PSEL && M_PENABLE && M_PREADY) begin
            check("apb_expected", 32'(apb_exp.size() != 0), 32'd1);
            if (apb_exp.size() != 0) begin
                a = apb_exp.pop_front();
                check("paddr", 32'(M_PADDR), 32'(a.paddr));
                check("pwrite", 32'(M_PWRITE), 32'(a.pwrite));
                if (a.pwrite) check("pwdata", M_PWDATA, a.pwdata);
            end
        end
    end

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] resp, input bit apb);
        exp_t e;
        apb_t a;
        e.is_write = 1'b1; e.data = 32'h0; e.resp = resp;
        sb.push_back(e);
        if (apb) begin
            a.paddr = {addr[PW-1:2], 2'b00}; a.pwdata = data; a.pwrite = 1'b1;
            apb_exp.push_back(a);
        end
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input bit apb);
        exp_t e;
        apb_t a;
        e.is_write = 1'b0; e.data = data; e.resp = resp;
        sb.push_back(e);
        if (apb) begin
            a.paddr = {addr[PW-1:2], 2'b00}; a.pwdata = 32'h0; a.pwrite = 1'b0;
            apb_exp.push_back(a);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input bit apb);
        int n = 0;
        S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        push_write(addr, data, resp, apb);
        #1;
        while (!(S_AWREADY && S_WREADY) && n < 64) begin
            @(negedge ACLK); #1; n++;
        end
        check("aw_w_handshake", 32'(S_AWREADY && S_WREADY), 32'd1);
        hs_cyc = cyc;
        @(negedge ACLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input bit apb);
        int n = 0;
        S_ARADDR = addr; S_ARVALID = 1'b1;
        push_read(addr, data, resp, apb);
        #1;
        while (!S_ARREADY && n < 64) begin
            @(negedge ACLK); #1; n++;
        end
        check("ar_handshake", 32'(S_ARREADY), 32'd1);
        hs_cyc = cyc;
        @(negedge ACLK);
        S_ARVALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge ACLK); n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        check("apb_drained", 32'(apb_exp.size()), 32'd0);
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = 4'h0; S_WVALID = 1'b0;
        S_BREADY = 1'b1; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b1;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_awready", 32'(S_AWREADY), 32'd0);
        check("rst_wready", 32'(S_WREADY), 32'd0);
        check("rst_arready", 32'(S_ARREADY), 32'd0);
        check("rst_bvalid", 32'(S_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_RVALID), 32'd0);
        check("rst_psel", 32'(M_PSEL), 32'd0);
        check("rst_penable", 32'(M_PENABLE), 32'd0);
        check("rst_pwrite", 32'(M_PWRITE), 32'd0);
        check("rst_paddr", 32'(M_PADDR), 32'd0);
        check("rst_pwdata", M_PWDATA, 32'd0);
        check("rst_rdata", S_RDATA, 32'd0);
        check("rst_bresp", 32'(S_BRESP), 32'd0);
        check("rst_rresp", 32'(S_RRESP), 32'd0);
        check("rst_timeout", 32'(TIMEOUT), 32'd0);
        nRST = 1'b1;
        repeat (2) @(negedge ACLK);

        // Round-robin with both sides requesting; read wins first after reset
        slv_mix = 1'b1; slv_rdata = 32'hA5A5_0000; slv_wait = 0;
        S_ARADDR = 32'h100; S_ARVALID = 1'b1;
        S_AWADDR = 32'h200; S_WDATA = 32'h1111_1111; S_WSTRB = 4'hF;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        push_read(32'h100, 32'hA5A5_0100, RESP_OKAY, 1'b1);
        push_write(32'h200, 32'h1111_1111, RESP_OKAY, 1'b1);
        push_read(32'h104, 32'hA5A5_0104, RESP_OKAY, 1'b1);
        push_write(32'h204, 32'h2222_2222, RESP_OKAY, 1'b1);
        rd_n = 0; wr_n = 0;
        for (int c = 0; c < 100 && (rd_n < 2 || wr_n < 2); c++) begin
            #1;
            rd_hs = S_ARVALID && S_ARREADY;
            wr_hs = S_AWVALID && S_AWREADY && S_WREADY;
            if (rd_hs) grants.push_back(1'b0);
            if (wr_hs) grants.push_back(1'b1);
            @(negedge ACLK);
            if (rd_hs) begin
                rd_n++;
                if (rd_n == 2) S_ARVALID = 1'b0;
                else S_ARADDR = 32'h104;
            end
            if (wr_hs) begin
                wr_n++;
                if (wr_n == 2) begin
                    S_AWVALID = 1'b0; S_WVALID = 1'b0;
                end else begin
                    S_AWADDR = 32'h204; S_WDATA = 32'h2222_2222;
                end
            end
        end
        check("arb_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check($sformatf("arb_grant_%0d", i), 32'(grants[i]), 32'(i % 2));
        end
        drain("arb_drain");
        slv_mix = 1'b0;

        // Zero-wait write: PADDR/PWDATA checked by the APB monitor
        axi_write(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, 1'b1);
        drain("wr_drain");
        check("wr_bvalid_latency", 32'(b_cyc - hs_cyc), 32'd3);

        // Read with three wait states
        slv_wait = 3; slv_rdata = 32'h1234_5678; pen_cnt = 0;
        axi_read(32'h0000_0024, 32'h1234_5678, RESP_OKAY, 1'b1);
        drain("rd_wait_drain");
        check("rd_wait_penable_cycles", 32'(pen_cnt), 32'd4);
        slv_wait = 0;

        // Partial strobe: SLVERR with no APB transfer, response in the next cycle
        rise0 = psel_rise;
        axi_write(32'h0000_0040, 32'hCAFE_F00D, 4'h3, RESP_SLVERR, 1'b0);
        drain("partial_drain");
        check("partial_no_psel", 32'(psel_rise - rise0), 32'd0);
        check("partial_bvalid_latency", 32'(b_cyc - hs_cyc), 32'd1);

        // Slave error on a read
        slv_err = 1'b1;
        axi_read(32'h0000_0028, 32'h1234_5678, RESP_SLVERR, 1'b1);
        drain("pslverr_drain");
        slv_err = 1'b0;

        // PREADY on the last permitted ACCESS cycle still succeeds
        slv_wait = TMO - 1; pen_cnt = 0;
        axi_read(32'h0000_002C, 32'h1234_5678, RESP_OKAY, 1'b1);
        drain("edge_drain");
        check("edge_penable_cycles", 32'(pen_cnt), 32'(TMO));
        check("edge_timeout_clear", 32'(TIMEOUT), 32'd0);
        slv_wait = 0;

        // Hung slave: abort after TMO ACCESS cycles
        slv_hang = 1'b1; pen_cnt = 0;
        axi_read(32'h0000_0030, 32'h0, RESP_SLVERR, 1'b0);
        drain("tmo_drain");
        check("tmo_penable_cycles", 32'(pen_cnt), 32'(TMO));
        check("tmo_flag_set", 32'(TIMEOUT), 32'd1);
        slv_hang = 1'b0;

        // A good read afterwards; the flag stays sticky
        slv_rdata = 32'h0BAD_CAFE;
        axi_read(32'h0000_0034, 32'h0BAD_CAFE, RESP_OKAY, 1'b1);
        drain("post_tmo_drain");
        check("tmo_flag_sticky", 32'(TIMEOUT), 32'd1);

        // Reset asserted during ACCESS
        slv_hang = 1'b1;
        S_ARADDR = 32'h0000_0038; S_ARVALID = 1'b1;
        n_wait = 0;
        #1;
        while (!S_ARREADY && n_wait < 64) begin
            @(negedge ACLK); #1; n_wait++;
        end
        check("rst_mid_ar_handshake", 32'(S_ARREADY), 32'd1);
        @(negedge ACLK);
        S_ARVALID = 1'b0;
        n_wait = 0;
        while (!M_PENABLE && n_wait < 16) begin
            @(negedge ACLK); n_wait++;
        end
        check("rst_mid_in_access", 32'(M_PENABLE), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_psel", 32'(M_PSEL), 32'd0);
        check("rst_mid_penable", 32'(M_PENABLE), 32'd0);
        check("rst_mid_paddr", 32'(M_PADDR), 32'd0);
        check("rst_mid_pwdata", M_PWDATA, 32'd0);
        check("rst_mid_rdata", S_RDATA, 32'd0);
        check("rst_mid_bresp", 32'(S_BRESP), 32'd0);
        check("rst_mid_rresp", 32'(S_RRESP), 32'd0);
        check("rst_mid_rvalid", 32'(S_RVALID), 32'd0);
        check("rst_mid_timeout", 32'(TIMEOUT), 32'd0);
        repeat (3) @(negedge ACLK);
        check("rst_mid_no_resp", 32'(S_RVALID || S_BVALID), 32'd0);
        slv_hang = 1'b0;
        nRST = 1'b1;
        repeat (2) @(negedge ACLK);
        slv_rdata = 32'h5555_AAAA;
        axi_read(32'h0000_003C, 32'h5555_AAAA, RESP_OKAY, 1'b1);
        drain("post_rst_drain");
        check("post_rst_timeout", 32'(TIMEOUT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
